nixie_scan_decoder: RTL and testbench



---
 rtl/display_pkg.sv | 21 ++
 rtl/decoder_4to10.sv | 11 +
 rtl/nixie_scan_decoder.sv | 115 +++++++++++
 tb/tb_nixie_scan_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and the BCD to one-of-ten decode used by decimal display drivers.
package display_pkg;

  localparam int NUM_CATHODES = 10;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Codes 10-15 have no cathode, so they return all-zero.
  function automatic logic [NUM_CATHODES-1:0] bcd_to_onehot10(input bcd_t code);
    if (code < 4'd10) begin
      return {{(NUM_CATHODES-1){1'b0}}, 1'b1} << code;
    end
    return '0;
  endfunction

endpackage

// File: rtl/decoder_4to10.sv
// Combinational BCD digit to one-hot cathode decode.
module decoder_4to10
  import display_pkg::*;
(
  input  bcd_t                    i_code,
  output logic [NUM_CATHODES-1:0] o_onehot
);

  assign o_onehot = bcd_to_onehot10(i_code);

endmodule

// File: rtl/nixie_scan_decoder.sv
// Multiplexed BCD display scanner: double-buffered frame, blank gap before every digit.
module nixie_scan_decoder
  import display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*DIGITS-1:0]     bcd,
  output logic [DIGITS-1:0]       anode,
  output logic [NUM_CATHODES-1:0] cathode,
  output logic                    frame_start,
  output logic                    bad_code
);

  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  scan_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [4*DIGITS-1:0]     r_pending, r_active;
  logic                    r_pending_full;
  logic [DIGITS-1:0]       r_anode;
  logic [NUM_CATHODES-1:0] r_cathode;
  logic                    r_frame_start, r_bad_code;
  bcd_t                    w_digit;
  logic [NUM_CATHODES-1:0] w_onehot;
  logic                    w_frame_edge, w_accept;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
        w_state_nxt = ST_SHOW;
        w_cnt_nxt   = '0;
      end
      ST_SHOW: if (r_cnt == CNT_W'(DWELL_CYC - 1)) begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Outputs are registered from the current scan position, so the edge that
  // raises frame_start is also the frame boundary where buffers swap.
  assign w_frame_edge = (r_state == ST_BLANK) && (r_cnt == '0) && (r_idx == '0);
  assign w_accept     = load_valid && !r_pending_full;

  // NOTE: the digit buffers are reset because the display must come up blank (all 4'hF), not random.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_active       <= '1;
    end else if (w_frame_edge && r_pending_full) begin
      r_active       <= r_pending;
      r_pending_full <= 1'b0;
    end else if (w_accept) begin
      r_pending      <= bcd;
      r_pending_full <= 1'b1;
    end
  end

  assign w_digit = r_active[4*r_idx +: 4];

  decoder_4to10 u_decoder (
    .i_code   (w_digit),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode       <= '0;
      r_cathode     <= '0;
      r_frame_start <= 1'b0;
      r_bad_code    <= 1'b0;
    end else begin
      r_anode       <= (r_state == ST_SHOW) ? (DIGITS'(1) << r_idx) : '0;
      r_cathode     <= (r_state == ST_SHOW) ? w_onehot : '0;
      r_frame_start <= w_frame_edge;
      r_bad_code    <= (r_state == ST_SHOW) && (w_digit > 4'd9);
    end
  end

  assign anode       = r_anode;
  assign cathode     = r_cathode;
  assign frame_start = r_frame_start;
  assign bad_code    = r_bad_code;
  assign load_ready  = !r_pending_full;

endmodule

// File: tb/tb_nixie_scan_decoder.sv
// Directed bench for nixie_scan_decoder: 4 digits, 2 blank + 8 lit cycles, 40-cycle frame.
module tb_nixie_scan_decoder;

  localparam int DIGITS = 4;
  localparam int DWELL  = 8;
  localparam int BLANK  = 2;
  localparam int SLOT   = DWELL + BLANK;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] bcd;
  logic [3:0]  anode;
  logic [9:0]  cathode;
  logic        frame_start;
  logic        bad_code;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = -1;

  nixie_scan_decoder #(
    .DIGITS    (DIGITS),
    .DWELL_CYC (DWELL),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .bcd         (bcd),
    .anode       (anode),
    .cathode     (cathode),
    .frame_start (frame_start),
    .bad_code    (bad_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected scan outputs for the current cycle when digits 'shown' are active.
  task automatic check_cycle(input logic [15:0] shown);
    int         pos, slot, off;
    logic [3:0] d;
    logic [3:0] exp_an;
    logic [9:0] exp_ca;
    logic       exp_bad;
    pos  = cyc % FRAME;
    slot = pos / SLOT;
    off  = pos % SLOT;
    d    = shown[slot*4 +: 4];
    if (off < BLANK) begin
      exp_an  = 4'b0000;
      exp_ca  = 10'd0;
      exp_bad = 1'b0;
    end else begin
      exp_an  = 4'b0001 << slot;
      exp_ca  = (d < 4'd10) ? (10'd1 << d) : 10'd0;
      exp_bad = (d >= 4'd10);
    end
    check("anode", anode, exp_an);
    check("cathode", cathode, exp_ca);
    check("bad_code", bad_code, exp_bad);
    check("frame_start", frame_start, pos == 0);
  endtask

  task automatic run_to(input int target, input logic [15:0] shown, input logic exp_rdy);
    while (cyc < target) begin
      step();
      check_cycle(shown);
      check("load_ready", load_ready, exp_rdy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    bcd        = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_anode", anode, 4'b0000);
    check("rst_cathode", cathode, 10'd0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_bad_code", bad_code, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);

    // Blank display after reset, load 4321 at cycle 5.
    @(negedge clk) rst = 1'b0;
    cyc = -1;
    run_to(5, 16'hFFFF, 1'b1);
    load_valid = 1'b1;
    bcd        = 16'h4321;
    step();
    load_valid = 1'b0;
    check_cycle(16'hFFFF);
    check("ready_drop", load_ready, 1'b0);
    run_to(39, 16'hFFFF, 1'b0);
    run_to(40, 16'h4321, 1'b1);
    run_to(42, 16'h4321, 1'b1);
    check("pos0_4321", cathode, 10'b0000000010);
    run_to(72, 16'h4321, 1'b1);
    check("pos3_4321", cathode, 10'b0000010000);
    run_to(80, 16'h4321, 1'b1);

    // Load 1234 and immediately offer 9999: held until the next frame swap.
    load_valid = 1'b1;
    bcd        = 16'h1234;
    step();
    bcd = 16'h9999;
    check_cycle(16'h4321);
    check("ready_stall", load_ready, 1'b0);
    run_to(119, 16'h4321, 1'b0);
    run_to(120, 16'h1234, 1'b1);
    step();
    load_valid = 1'b0;
    check_cycle(16'h1234);
    check("second_accept", load_ready, 1'b0);
    run_to(122, 16'h1234, 1'b0);
    check("pos0_1234", cathode, 10'b0000010000);
    run_to(159, 16'h1234, 1'b0);
    run_to(161, 16'h9999, 1'b1);

    // Mixed valid and invalid codes.
    load_valid = 1'b1;
    bcd        = 16'hA0B5;
    step();
    load_valid = 1'b0;
    check_cycle(16'h9999);
    check("ready_a0b5", load_ready, 1'b0);
    check("pos0_9999", cathode, 10'b1000000000);
    run_to(199, 16'h9999, 1'b0);
    run_to(202, 16'hA0B5, 1'b1);
    check("pos0_a0b5", cathode, 10'b0000100000);
    check("pos0_a0b5_ok", bad_code, 1'b0);
    run_to(210, 16'hA0B5, 1'b1);
    check("pos1_blank_nobad", bad_code, 1'b0);
    run_to(212, 16'hA0B5, 1'b1);
    check("pos1_a0b5", cathode, 10'd0);
    check("pos1_a0b5_bad", bad_code, 1'b1);
    run_to(222, 16'hA0B5, 1'b1);
    check("pos2_a0b5", cathode, 10'b0000000001);
    run_to(232, 16'hA0B5, 1'b1);
    check("pos3_a0b5_bad", bad_code, 1'b1);
    run_to(241, 16'hA0B5, 1'b1);

    // Pending 8888, then asynchronous reset mid SHOW of position 2.
    load_valid = 1'b1;
    bcd        = 16'h8888;
    step();
    load_valid = 1'b0;
    check_cycle(16'hA0B5);
    check("ready_8888", load_ready, 1'b0);
    run_to(263, 16'hA0B5, 1'b0);
    check("pre_rst_anode", anode, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_anode", anode, 4'b0000);
    check("async_cathode", cathode, 10'd0);
    check("async_frame_start", frame_start, 1'b0);
    check("async_bad_code", bad_code, 1'b0);
    check("async_load_ready", load_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    cyc = -1;
    run_to(79, 16'hFFFF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
